// File: rtl/cpu_trace_checker.sv
// Trace-stream checker: parses one ASCII character per clock, recognises register-write and
// memory-write records, and reports format/window errors in the cycle after the closing '#'.
module cpu_trace_checker #(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter bit          ALLOW_UPPER = 1'b0,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter int unsigned GRF_MAX     = 31,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [31:0]      last_pc,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int unsigned TW = $clog2(10 ** TIME_DIGITS);
  localparam int unsigned GW = $clog2(10 ** GRF_DIGITS);
  localparam logic [3:0]  TD = 4'(TIME_DIGITS);
  localparam logic [3:0]  GD = 4'(GRF_DIGITS);

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SP1, S_GRF, S_ADDR, S_SP2, S_LT, S_EQ_SP, S_DATA, S_SP3, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TW-1:0]     time_q, time_d;
  logic [GW-1:0]     grf_q, grf_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic              is_mem_q, is_mem_d;
  logic [1:0]        format_type_q;
  logic [3:0]        error_code_q;
  logic [31:0]       last_pc_q;
  logic [CNT_W-1:0]  rec_cnt_q, err_cnt_q;
  logic [15:0]       half_s;
  logic [3:0]        err_s;
  logic              done_s;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66)) ||
           (ALLOW_UPPER && (c >= 8'h41) && (c <= 8'h46));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] v;
    if (is_dec(c)) v = c - 8'h30;
    else if (c >= 8'h61) v = c - 8'h57;
    else v = c - 8'h37;
    return v[3:0];
  endfunction

  // Offset compare folds both bounds into one unsigned test and stays valid when lo is zero.
  function automatic logic out_of_window(input logic [31:0] v, input logic [31:0] lo,
                                         input logic [31:0] hi);
    return ((v - lo) > (hi - lo)) || (v[1:0] != 2'b00);
  endfunction

  assign half_s = freq >> 4'd1;
  assign err_s[0] = (half_s != 16'd0) && ((32'(time_q) % 32'(half_s)) != 32'd0);
  assign err_s[1] = out_of_window(pc_q, PC_LO, PC_HI);
  assign err_s[2] = is_mem_q && out_of_window(addr_q, ADDR_LO, ADDR_HI);
  assign err_s[3] = !is_mem_q && (32'(grf_q) > GRF_MAX);
  assign done_s   = (state_d == S_DONE);

  // Record parser: next state and field accumulators.
  always_comb begin
    state_d  = S_IDLE;
    cnt_d    = cnt_q;
    time_d   = time_q;
    grf_d    = grf_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    is_mem_d = is_mem_q;
    if (char == CH_CARET) begin
      state_d  = S_TIME;
      cnt_d    = 4'd0;
      time_d   = {TW{1'b0}};
      grf_d    = {GW{1'b0}};
      pc_d     = 32'd0;
      addr_d   = 32'd0;
      is_mem_d = 1'b0;
    end else begin
      case (state_q)
        S_TIME: begin
          if (is_dec(char) && (cnt_q < TD)) begin
            state_d = S_TIME;
            cnt_d   = cnt_q + 4'd1;
            time_d  = time_q * TW'(4'd10) + TW'(hex_val(char));
          end else if ((char == CH_AT) && (cnt_q != 4'd0)) begin
            state_d = S_PC;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex(char) && (cnt_q < 4'd8)) begin
            state_d = S_PC;
            cnt_d   = cnt_q + 4'd1;
            pc_d    = {pc_q[27:0], hex_val(char)};
          end else if ((char == CH_COLON) && (cnt_q == 4'd8)) begin
            state_d = S_SP1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SP1: begin
          if (char == CH_SP) begin
            state_d = S_SP1;
          end else if (char == CH_DOLLAR) begin
            state_d  = S_GRF;
            cnt_d    = 4'd0;
            is_mem_d = 1'b0;
          end else if (char == CH_STAR) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            is_mem_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GRF: begin
          if (is_dec(char) && (cnt_q < GD)) begin
            state_d = S_GRF;
            cnt_d   = cnt_q + 4'd1;
            grf_d   = grf_q * GW'(4'd10) + GW'(hex_val(char));
          end else if ((char == CH_SP) && (cnt_q != 4'd0)) begin
            state_d = S_SP2;
          end else if ((char == CH_LT) && (cnt_q != 4'd0)) begin
            state_d = S_LT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          if (is_hex(char) && (cnt_q < 4'd8)) begin
            state_d = S_ADDR;
            cnt_d   = cnt_q + 4'd1;
            addr_d  = {addr_q[27:0], hex_val(char)};
          end else if ((char == CH_SP) && (cnt_q == 4'd8)) begin
            state_d = S_SP2;
          end else if ((char == CH_LT) && (cnt_q == 4'd8)) begin
            state_d = S_LT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SP2: begin
          if (char == CH_SP) state_d = S_SP2;
          else if (char == CH_LT) state_d = S_LT;
          else state_d = S_IDLE;
        end
        S_LT: begin
          if (char == CH_EQ) state_d = S_EQ_SP;
          else state_d = S_IDLE;
        end
        S_EQ_SP: begin
          if (char == CH_SP) begin
            state_d = S_EQ_SP;
          end else if (is_hex(char)) begin
            state_d = S_DATA;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (is_hex(char) && (cnt_q < 4'd8)) begin
            state_d = S_DATA;
            cnt_d   = cnt_q + 4'd1;
          end else if ((char == CH_SP) && (cnt_q == 4'd8)) begin
            state_d = S_SP3;
          end else if ((char == CH_HASH) && (cnt_q == 4'd8)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SP3: begin
          if (char == CH_SP) state_d = S_SP3;
          else if (char == CH_HASH) state_d = S_DONE;
          else state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Parser state, result outputs and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      time_q        <= {TW{1'b0}};
      grf_q         <= {GW{1'b0}};
      pc_q          <= 32'd0;
      addr_q        <= 32'd0;
      is_mem_q      <= 1'b0;
      format_type_q <= 2'd0;
      error_code_q  <= 4'd0;
      last_pc_q     <= 32'd0;
      rec_cnt_q     <= {CNT_W{1'b0}};
      err_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      grf_q    <= grf_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      is_mem_q <= is_mem_d;
      if (done_s) begin
        format_type_q <= is_mem_q ? 2'd2 : 2'd1;
        error_code_q  <= err_s;
        last_pc_q     <= pc_q;
        if (rec_cnt_q != {CNT_W{1'b1}}) rec_cnt_q <= rec_cnt_q + CNT_W'(1'b1);
        if ((err_s != 4'd0) && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_q <= err_cnt_q + CNT_W'(1'b1);
      end else begin
        format_type_q <= 2'd0;
        error_code_q  <= 4'd0;
      end
    end
  end

  assign format_type = format_type_q;
  assign error_code  = error_code_q;
  assign last_pc     = last_pc_q;
  assign rec_cnt     = rec_cnt_q;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: two instances (lower-case only with 4-bit counters, upper-case
// allowed with 16-bit counters) fed the same stream and compared against a string-level record model.
module tb_cpu_trace_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ch;
  logic [15:0] freq;
  logic [1:0]  ft0, ft1;
  logic [3:0]  ec0, ec1;
  logic [31:0] lpc0, lpc1;
  logic [3:0]  rc0, erc0;
  logic [15:0] rc1, erc1;
  int checks = 0;
  int errors = 0;
  bit run_q = 1'b0;

  string       rec_buf_q;
  bit          in_rec_q;
  logic [1:0]  exp_ft  [2];
  logic [3:0]  exp_ec  [2];
  logic [31:0] exp_pc  [2];
  int          exp_rec [2];
  int          exp_err [2];

  always #5 clk = ~clk;

  cpu_trace_checker #(.ALLOW_UPPER(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .char(ch), .freq(freq), .format_type(ft0), .error_code(ec0),
    .last_pc(lpc0), .rec_cnt(rc0), .err_cnt(erc0));

  cpu_trace_checker #(.ALLOW_UPPER(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .char(ch), .freq(freq), .format_type(ft1), .error_code(ec1),
    .last_pc(lpc1), .rec_cnt(rc1), .err_cnt(erc1));

  function automatic bit m_dec(logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit m_hex(logic [7:0] c, bit up);
    return m_dec(c) || ((c >= "a") && (c <= "f")) || (up && (c >= "A") && (c <= "F"));
  endfunction

  function automatic logic [7:0] at(string s, int i);
    if (i < s.len()) return s[i];
    return 8'h00;
  endfunction

  function automatic int run_len(string s, int i, bit hex, bit up);
    int k = 0;
    while (hex ? m_hex(at(s, i + k), up) : m_dec(at(s, i + k))) k++;
    return k;
  endfunction

  function automatic longint unsigned num(string s, int i, int k, int base);
    longint unsigned v = 0;
    for (int j = 0; j < k; j++) begin
      int c = int'(at(s, i + j));
      int d = m_dec(8'(c)) ? c - 48 : ((c >= 97) ? c - 87 : c - 55);
      v = v * longint'(base) + longint'(d);
    end
    return v;
  endfunction

  // Whole-record grammar check on the text after '^'; returns {ok, format, error bits, pc}.
  function automatic logic [38:0] parse_rec(string s, bit up, logic [15:0] fr);
    int i, k;
    longint unsigned tm, gr, ad, half;
    logic [31:0] pcv;
    logic [3:0] ec;
    bit mem;
    gr = 0; ad = 0; mem = 0; ec = 4'd0;
    k = run_len(s, 0, 0, up);
    if (k < 1 || k > 4) return 39'd0;
    tm = num(s, 0, k, 10); i = k;
    if (at(s, i) != "@") return 39'd0;
    i++;
    if (run_len(s, i, 1, up) != 8) return 39'd0;
    pcv = 32'(num(s, i, 8, 16)); i += 8;
    if (at(s, i) != ":") return 39'd0;
    i++;
    while (at(s, i) == " ") i++;
    if (at(s, i) == "$") begin
      i++;
      k = run_len(s, i, 0, up);
      if (k < 1 || k > 4) return 39'd0;
      gr = num(s, i, k, 10); i += k;
    end else if (at(s, i) == "*") begin
      mem = 1; i++;
      if (run_len(s, i, 1, up) != 8) return 39'd0;
      ad = num(s, i, 8, 16); i += 8;
    end else begin
      return 39'd0;
    end
    while (at(s, i) == " ") i++;
    if (at(s, i) != "<") return 39'd0;
    i++;
    if (at(s, i) != "=") return 39'd0;
    i++;
    while (at(s, i) == " ") i++;
    if (run_len(s, i, 1, up) != 8) return 39'd0;
    i += 8;
    while (at(s, i) == " ") i++;
    if (at(s, i) != "#" || i != s.len() - 1) return 39'd0;
    half = longint'(fr) / 2;
    if (half != 0) ec[0] = (tm % half) != 0;
    ec[1] = (pcv < 32'h3000) || (pcv > 32'h4fff) || (pcv % 4 != 0);
    ec[2] = mem && ((ad > 32'h2fff) || (ad % 4 != 0));
    ec[3] = !mem && (gr > 31);
    return {1'b1, (mem ? 2'd2 : 2'd1), ec, pcv};
  endfunction

  function automatic int cnt_max(int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  // Reference model: buffers text since the last '^' and judges it when '#' arrives.
  always @(posedge clk) begin
    if (reset) begin
      rec_buf_q <= "";
      in_rec_q  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        exp_ft[k] <= 2'd0; exp_ec[k] <= 4'd0; exp_pc[k] <= 32'd0;
        exp_rec[k] <= 0; exp_err[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_ft[k] <= 2'd0; exp_ec[k] <= 4'd0;
      end
      if (ch == "^") begin
        rec_buf_q <= "";
        in_rec_q  <= 1'b1;
      end else if (in_rec_q && ch == "#") begin
        in_rec_q <= 1'b0;
        for (int k = 0; k < 2; k++) begin
          automatic logic [38:0] r = parse_rec($sformatf("%s#", rec_buf_q), k == 1, freq);
          if (r[38]) begin
            exp_ft[k]  <= r[37:36];
            exp_ec[k]  <= r[35:32];
            exp_pc[k]  <= r[31:0];
            exp_rec[k] <= (exp_rec[k] < cnt_max(k)) ? exp_rec[k] + 1 : exp_rec[k];
            if (r[35:32] != 4'd0 && exp_err[k] < cnt_max(k)) exp_err[k] <= exp_err[k] + 1;
          end
        end
      end else if (in_rec_q) begin
        rec_buf_q <= $sformatf("%s%c", rec_buf_q, ch);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_q) begin
      check("ft0", 32'(ft0), 32'(exp_ft[0]));
      check("ec0", 32'(ec0), 32'(exp_ec[0]));
      check("last_pc0", lpc0, exp_pc[0]);
      check("rec_cnt0", 32'(rc0), 32'(exp_rec[0]));
      check("err_cnt0", 32'(erc0), 32'(exp_err[0]));
      check("ft1", 32'(ft1), 32'(exp_ft[1]));
      check("ec1", 32'(ec1), 32'(exp_ec[1]));
      check("last_pc1", lpc1, exp_pc[1]);
      check("rec_cnt1", 32'(rc1), 32'(exp_rec[1]));
      check("err_cnt1", 32'(erc1), 32'(exp_err[1]));
    end
  end

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1 ch = s[i];
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1 ch = 8'h20;
    end
  endtask

  // Leaves the bench inside the DONE cycle of a record ending in '#'.
  task automatic send_rec(string s);
    send_str(s);
    idle(1);
  endtask

  function automatic string spaces(int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  function automatic string mix_case(string s);
    string o = "";
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c = s[i];
      if (c >= "a" && c <= "f" && $urandom_range(0, 1) == 1) c = c - 8'd32;
      o = $sformatf("%s%c", o, c);
    end
    return o;
  endfunction

  function automatic string corrupt(string s);
    string pool = "  $*<=#@:^0aF9";
    string o = "";
    int pos = $urandom_range(1, s.len() - 2);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c = s[i];
      if (i == pos) c = pool[$urandom_range(0, pool.len() - 1)];
      o = $sformatf("%s%c", o, c);
    end
    return o;
  endfunction

  task automatic send_random();
    string s, d;
    logic [31:0] pcv, adv;
    int r;
    freq = 16'($urandom_range(0, 9));
    r = $urandom_range(0, 15);
    s = $sformatf("^%0d@", (r == 0) ? $urandom_range(10000, 99999) : $urandom_range(0, 9999));
    case ($urandom_range(0, 3))
      0: pcv = 32'h3000 + 32'($urandom_range(0, 2047)) * 32'd4;
      1: pcv = 32'h3000 + 32'($urandom_range(0, 8191));
      2: pcv = $urandom;
      default: pcv = r[0] ? 32'h2ffc : 32'h5000;
    endcase
    s = {s, $sformatf("%08h:", pcv), spaces($urandom_range(0, 2))};
    if ($urandom_range(0, 1) == 1) begin
      s = {s, $sformatf("$%0d", ($urandom_range(0, 9) == 0) ? $urandom_range(10000, 99999)
                                                             : $urandom_range(0, 40))};
    end else begin
      adv = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3071)) * 32'd4
                                         : 32'($urandom_range(0, 32'h3100));
      s = {s, $sformatf("*%08h", adv)};
    end
    s = {s, spaces($urandom_range(0, 2)), "<=", spaces($urandom_range(0, 2))};
    d = $sformatf("%08h", $urandom);
    r = $urandom_range(0, 9);
    if (r == 0) d = d.substr(0, 6);
    else if (r == 1) d = {d, "5"};
    s = {s, d, spaces($urandom_range(0, 1)), "#"};
    if ($urandom_range(0, 3) == 0) s = mix_case(s);
    if ($urandom_range(0, 7) == 0) s = corrupt(s);
    send_rec(s);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    reset = 1'b1; ch = 8'h20; freq = 16'd2;
    @(posedge clk); #1 run_q = 1'b1;
    check("reset_ft", 32'(ft0), 32'd0);
    check("reset_ec", 32'(ec0), 32'd0);
    check("reset_last_pc", lpc0, 32'd0);
    check("reset_rec_cnt", 32'(rc0), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    send_rec("^242@000030f4: $31 <=12345678#");
    check("reg_ft", 32'(ft0), 32'd1);
    check("reg_ec", 32'(ec0), 32'd0);
    check("reg_rec_cnt", 32'(rc0), 32'd1);
    check("reg_last_pc", lpc0, 32'h30f4);
    idle(1);
    check("ft_cleared_after_done", 32'(ft0), 32'd0);

    send_rec("^338@00003130: *00000088 <= ffffb528#");
    check("mem_ft", 32'(ft0), 32'd2);
    check("mem_ec", 32'(ec0), 32'd0);

    send_rec("^338@00003130: *00000088 <= Ffffb528#");
    check("upper_ft_lower_only", 32'(ft0), 32'd0);
    check("upper_ft_upper_ok", 32'(ft1), 32'd2);

    freq = 16'd4;
    send_rec("^243@00003002: $32 <=00000000#");
    check("err_ft", 32'(ft0), 32'd1);
    check("err_ec", 32'(ec0), 32'hb);
    check("err_cnt_1", 32'(erc0), 32'd1);

    freq = 16'd2;
    send_rec("^1@00004ffc: *00003000 <=00000000#");
    check("addr_ft", 32'(ft0), 32'd2);
    check("addr_ec", 32'(ec0), 32'h4);
    check("rec_cnt_4", 32'(rc0), 32'd4);
    check("rec_cnt_5", 32'(rc1), 32'd5);

    send_rec("^338@00003130: *00000088 <= ffffb52#");
    check("data7_ft", 32'(ft0), 32'd0);
    send_rec("^338@00003130: *00000088 <= ffffb5281#");
    check("data9_ft", 32'(ft0), 32'd0);
    send_rec("^338@00003130: *00000088 <=   12321 5 #");
    check("inner_sp_ft", 32'(ft0), 32'd0);
    send_rec("^338@00003130: *00000088 <=#");
    check("empty_data_ft", 32'(ft0), 32'd0);
    check("malformed_rec_cnt", 32'(rc0), 32'd4);

    send_rec("^338@0000^242@000030f4: $31 <=12345678#");
    check("restart_ft", 32'(ft0), 32'd1);
    check("restart_rec_cnt", 32'(rc0), 32'd5);

    repeat (300) send_random();
    freq = 16'd2;

    send_str("^242@000030f4: $31 <=12345678");
    @(posedge clk); #1 ch = "#"; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; ch = 8'h20;
    check("rst_hash_ft", 32'(ft0), 32'd0);
    check("rst_hash_ec", 32'(ec0), 32'd0);
    check("rst_hash_last_pc", lpc0, 32'd0);
    check("rst_hash_rec_cnt", 32'(rc1), 32'd0);

    repeat (17) send_rec("^242@000030f4: $31 <=12345678#");
    check("sat_ft", 32'(ft0), 32'd1);
    check("sat_rec_cnt0", 32'(rc0), 32'hf);
    check("sat_rec_cnt1", 32'(rc1), 32'd17);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
